muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

- Sequences the shared iterative multiply/divide core on behalf of the EX stage for RISC-V M-extension ops (funct3 000–111).
- Converts signed operands to magnitudes and issues a single-cycle start to the core.
- When the core finishes, applies sign fix-up and hi/lo or quotient/remainder selection.
- Resolves divide-by-zero and signed overflow without using the core.
- Stalls the pipeline until the result is delivered, and survives flushes even though the core has no abort and no reset.

## Interface
- WIDTH, 32, operand/result width
- DRAIN_CYCLES, 80, post-reset wait covering the longest core operation (≥ 2*WIDTH+8)
- Clk  in  1  clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- req_valid  in  1  M-op present in EX; held stable while stall=1
- req_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- req_a, req_b  in  WIDTH  rs1, rs2
- flush  in  1  kill in-flight op (mispredict)
- req_ready  out  1  high only in IDLE
- stall  out  1  req_valid && !resp_valid
- resp_valid  out  1  one-cycle pulse
- resp_data  out  WIDTH  result, registered
- core_execute  out  1  one-cycle start pulse to core
- core_div  out  1  1 = divide, 0 = multiply; held from ISSUE through WAIT
- core_a, core_b  out  WIDTH  operand magnitudes, registered at accept
- core_ready  in  1  core done pulse; core self-returns to idle
- core_prod  in  2*WIDTH  unsigned product
- core_quot, core_rem  in  WIDTH  unsigned quotient, remainder

## Operation
- States: INIT, IDLE, SPECIAL, ISSUE, WAIT, FIXUP, RESP, DRAIN.
- Accept when state is IDLE, req_valid=1 and flush=0. At accept, latch funct3, sign flags and magnitudes.
  - sa = signed_a && a[MSB]. signed_a holds for MULH, MULHSU, DIV, REM.
  - sb = signed_b && b[MSB]. signed_b holds for MULH, DIV, REM.
  - Magnitude = negative flag ? -x : x.
- Divide with b==0 goes to SPECIAL:
  - Quotient result = all ones.
  - Remainder result = a.
- DIV/REM with a=MIN and b=-1 goes to SPECIAL:
  - DIV result = MIN.
  - REM result = 0.
- Any other op goes to ISSUE. ISSUE drives core_execute=1 for one cycle, then moves to WAIT.
- WAIT → FIXUP on core_ready; the core result is latched at that edge.
- FIXUP registers resp_data:
  - MUL: low WIDTH bits of the product, negated over 2*WIDTH if sa^sb.
  - MULH/MULHSU/MULHU: high WIDTH bits of the same (conditionally negated) product.
  - DIV/DIVU: quotient, negated if sa^sb.
  - REM/REMU: remainder, negated if sa.
- SPECIAL → RESP. FIXUP → RESP.
- RESP drives resp_valid=1, then moves to IDLE. A new accept can occur in the following cycle.
- flush handling, by state:
  - IDLE: request is not accepted.
  - SPECIAL/FIXUP/RESP: go to IDLE next cycle; no resp_valid.
  - ISSUE/WAIT: go to DRAIN. DRAIN waits for core_ready, discards the result, then moves to IDLE.
  - A flush in the same cycle as core_ready in WAIT also goes to IDLE with the result discarded.
- INIT: Reset forces INIT with counter = DRAIN_CYCLES. Decrement each cycle; enter IDLE at 0. This lets a possibly busy, unresettable core finish.

## Timing
- Reset values: req_ready=0, stall=req_valid, resp_valid=0, resp_data=0, core_execute=0, core_div=0, core_a=core_b=0.
- Reset has priority over flush and req_valid.
- Latency is counted from the accept edge (cycle 0):
  - Special case: resp_valid in cycle 2.
  - Core path, core_ready sampled in cycle k: resp_valid in cycle k+2.
  - core_execute is high in cycle 1.
- stall falls combinationally in the RESP cycle. EX advances on that edge.
- req_ready=0 in every state except IDLE.

## Configuration
- MULDIV_RESULT_CACHE_EN defined: one-entry cache of {core_a, core_b, core_div, raw core result, valid}.
  - Written only on WAIT→FIXUP.
  - Invalidated by Reset.
  - A core-path request whose magnitudes and core_div match a valid entry skips ISSUE/WAIT: IDLE → FIXUP → RESP, resp_valid in cycle 2, no core_execute.
  - Sign fix-up uses the new request's flags, so MUL followed by MULH on the same operands hits.
- Undefined: no cache storage; every non-special op goes through the core.

## Test plan
- After Reset, req_ready=0 for exactly DRAIN_CYCLES cycles.
- MUL 6×7 → resp_data=42; one core_execute pulse; resp_valid 2 cycles after core_ready.
- MULH 0xFFFFFFFE × 3 → 0xFFFFFFFF.
- MULHU 0xFFFFFFFE × 3 → 0x00000002.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM of the same operands → 0xFFFFFFFF.
- DIVU 5/0 → 0xFFFFFFFF in cycle 2 with no core_execute. REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000.
- Flush during WAIT → no resp_valid and req_ready=0 until core_ready. The next MUL 3×3 → 9.
- Cache enabled: DIV −7/2, then REM −7/2 → second resp 0xFFFFFFFF in cycle 2, core_execute not pulsed.
- Cache disabled: the same REM pulses core_execute.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Sequencer for the shared iterative mul/div core on behalf of the EX stage.
// Define MULDIV_RESULT_CACHE_EN for a one-entry result cache.
module muldiv_sequencer #(
  parameter int WIDTH        = 32,
  parameter int DRAIN_CYCLES = 80
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               req_valid,
  input  logic [2:0]         req_funct3,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  input  logic               flush,
  output logic               req_ready,
  output logic               stall,
  output logic               resp_valid,
  output logic [WIDTH-1:0]   resp_data,
  output logic               core_execute,
  output logic               core_div,
  output logic [WIDTH-1:0]   core_a,
  output logic [WIDTH-1:0]   core_b,
  input  logic               core_ready,
  input  logic [2*WIDTH-1:0] core_prod,
  input  logic [WIDTH-1:0]   core_quot,
  input  logic [WIDTH-1:0]   core_rem
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    INIT, IDLE, SPECIAL, ISSUE, WAIT, FIXUP, RESP, DRAIN
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2:0]         f3;
  logic               sa;
  logic               sb;
  logic [2*WIDTH-1:0] raw;

  logic               sgn_a;
  logic               sgn_b;
  logic               na;
  logic               nb;
  logic               is_div;
  logic               zero_b;
  logic               ovf;
  logic               hit;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] hit_res;
  logic [2*WIDTH-1:0] core_raw;

  assign sgn_a = (req_funct3 == 3'b001) ||
                 (req_funct3 == 3'b010) ||
                 (req_funct3[2] && !req_funct3[0]);
  assign sgn_b = (req_funct3 == 3'b001) ||
                 (req_funct3[2] && !req_funct3[0]);
  assign na     = sgn_a && req_a[WIDTH-1];
  assign nb     = sgn_b && req_b[WIDTH-1];
  assign mag_a  = na ? -req_a : req_a;
  assign mag_b  = nb ? -req_b : req_b;
  assign is_div = req_funct3[2];
  assign zero_b = is_div && (req_b == '0);
  assign ovf    = is_div && sgn_a &&
                  (req_a == MIN) && (req_b == '1);

  assign core_raw = core_div ? {core_rem, core_quot}
                             : core_prod;

`ifdef MULDIV_RESULT_CACHE_EN
  logic               c_vld;
  logic               c_div;
  logic [WIDTH-1:0]   c_a;
  logic [WIDTH-1:0]   c_b;
  logic [2*WIDTH-1:0] c_res;

  assign hit = c_vld && (c_div == is_div) &&
               (c_a == mag_a) && (c_b == mag_b);
  assign hit_res = c_res;

  // Raw, sign-free result: later ops reuse it with their own signs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      c_vld <= 1'b0;
    end else if (state == WAIT && core_ready && !flush) begin
      c_vld <= 1'b1;
      c_div <= core_div;
      c_a   <= core_a;
      c_b   <= core_b;
      c_res <= core_raw;
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   q_s;
  logic [WIDTH-1:0]   r_s;
  logic [WIDTH-1:0]   fix;
  logic [WIDTH-1:0]   sp_a;
  logic [WIDTH-1:0]   spec;

  assign prod_s = (sa ^ sb) ? -raw : raw;
  assign q_s    = (sa ^ sb) ? -raw[WIDTH-1:0]
                            : raw[WIDTH-1:0];
  assign r_s    = sa ? -raw[2*WIDTH-1:WIDTH]
                     : raw[2*WIDTH-1:WIDTH];

  always_comb begin
    fix = '0;
    unique case (1'b1)
      (f3 == 3'b000):
        fix = prod_s[WIDTH-1:0];
      (!f3[2] && f3[1:0] != 2'b00):
        fix = prod_s[2*WIDTH-1:WIDTH];
      (f3[2:1] == 2'b10):
        fix = q_s;
      (f3[2:1] == 2'b11):
        fix = r_s;
    endcase
  end

  // Original dividend rebuilt from magnitude for the b==0 remainder.
  assign sp_a = sa ? -core_a : core_a;
  assign spec = (core_b == '0) ? (f3[1] ? sp_a : '1)
                               : (f3[1] ? '0 : MIN);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= INIT;
      cnt       <= CW'(DRAIN_CYCLES);
      f3        <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      raw       <= '0;
      resp_data <= '0;
      core_div  <= 1'b0;
      core_a    <= '0;
      core_b    <= '0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt - 1'b1;
          if (cnt <= CW'(1)) state <= IDLE;
        end
        IDLE: begin
          if (req_valid && !flush) begin
            f3       <= req_funct3;
            sa       <= na;
            sb       <= nb;
            core_div <= is_div;
            core_a   <= mag_a;
            core_b   <= mag_b;
            if (zero_b || ovf) begin
              state <= SPECIAL;
            end else if (hit) begin
              raw   <= hit_res;
              state <= FIXUP;
            end else begin
              state <= ISSUE;
            end
          end
        end
        SPECIAL: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            resp_data <= spec;
            state     <= RESP;
          end
        end
        ISSUE: state <= flush ? DRAIN : WAIT;
        WAIT: begin
          if (core_ready) begin
            if (flush) begin
              state <= IDLE;
            end else begin
              raw   <= core_raw;
              state <= FIXUP;
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        FIXUP: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            resp_data <= fix;
            state     <= RESP;
          end
        end
        RESP: state <= IDLE;
        DRAIN: if (core_ready) state <= IDLE;
        default: state <= INIT;
      endcase
    end
  end

  assign req_ready    = (state == IDLE);
  assign resp_valid   = (state == RESP) && !flush;
  assign stall        = req_valid && !resp_valid;
  assign core_execute = (state == ISSUE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer with a fixed-latency core model.
// Expectations for the cached REM depend on MULDIV_RESULT_CACHE_EN.
module tb_muldiv_sequencer;

  localparam int W    = 32;
  localparam int D    = 80;
  localparam int LAT  = 3;
  localparam int CLAT = LAT + 4;

  logic           Clk = 1'b0;
  logic           Reset;
  logic           req_valid;
  logic [2:0]     req_funct3;
  logic [W-1:0]   req_a;
  logic [W-1:0]   req_b;
  logic           flush;
  logic           req_ready;
  logic           stall;
  logic           resp_valid;
  logic [W-1:0]   resp_data;
  logic           core_execute;
  logic           core_div;
  logic [W-1:0]   core_a;
  logic [W-1:0]   core_b;
  logic           core_ready = 1'b0;
  logic [2*W-1:0] core_prod;
  logic [W-1:0]   core_quot;
  logic [W-1:0]   core_rem;

  muldiv_sequencer #(.WIDTH(W), .DRAIN_CYCLES(D)) dut (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid), .req_funct3(req_funct3),
    .req_a(req_a), .req_b(req_b), .flush(flush),
    .req_ready(req_ready), .stall(stall),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .core_execute(core_execute), .core_div(core_div),
    .core_a(core_a), .core_b(core_b),
    .core_ready(core_ready), .core_prod(core_prod),
    .core_quot(core_quot), .core_rem(core_rem)
  );

  always #5 Clk = ~Clk;

  // Core model: no reset, fixed latency, result held after done
  logic [W-1:0] ca = '0;
  logic [W-1:0] cb = '0;
  int busy = 0;
  always @(posedge Clk) begin
    core_ready <= 1'b0;
    if (core_execute) begin
      ca   <= core_a;
      cb   <= core_b;
      busy <= LAT;
    end else if (busy > 0) begin
      busy <= busy - 1;
      if (busy == 1) core_ready <= 1'b1;
    end
  end
  assign core_prod = {{W{1'b0}}, ca} * {{W{1'b0}}, cb};
  assign core_quot = (cb == '0) ? '1 : ca / cb;
  assign core_rem  = (cb == '0) ? ca : ca % cb;

  int cyc = 0;
  int exe_cnt = 0;
  int n_resp = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge Clk) begin
    cyc++;
    if (core_execute) exe_cnt++;
  end

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
    string        name;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (resp_valid) begin
      n_resp++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp act=%h exp=none", resp_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_data"}, resp_data, e.data);
        chk({e.name, "_cyc"}, W'(cyc), W'(e.cyc));
      end
    end
  end

  task automatic run_op(input string nm, input logic [2:0] f,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input int lat,
                        input int nexe);
    int n;
    int e0;
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge Clk); #1; n++;
    end
    req_valid  = 1'b1;
    req_funct3 = f;
    req_a      = a;
    req_b      = b;
    e0 = exe_cnt;
    exp_q.push_back('{data: exp, cyc: cyc + lat, name: nm});
    n = 0;
    @(negedge Clk);
    while (!resp_valid && n < 200) begin
      @(negedge Clk); n++;
    end
    if (n >= 200) chk({nm, "_timeout"}, 32'd1, 32'd0);
    @(posedge Clk); #1;
    req_valid = 1'b0;
    chk({nm, "_exec"}, W'(exe_cnt - e0), W'(nexe));
  endtask

  initial begin
    int n;
    int bad;
    int r0;
    Reset      = 1'b1;
    req_valid  = 1'b1;
    req_funct3 = '0;
    req_a      = '0;
    req_b      = '0;
    flush      = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_stall_hi", W'(stall), 32'd1);
    req_valid = 1'b0;
    #1;
    chk("rst_stall_lo", W'(stall), 32'd0);
    chk("rst_ready", W'(req_ready), 32'd0);
    chk("rst_resp_valid", W'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_exec", W'(core_execute), 32'd0);
    chk("rst_div", W'(core_div), 32'd0);
    chk("rst_core_a", core_a, 32'd0);
    chk("rst_core_b", core_b, 32'd0);
    Reset = 1'b0;
    n = 0;
    while (!req_ready && n < 1000) begin
      n++;
      @(posedge Clk); #1;
    end
    chk("init_cycles", W'(n), W'(D));

    run_op("mul", 3'b000, 32'd6, 32'd7, 32'd42, CLAT, 1);
    run_op("mulh", 3'b001, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, CLAT, 1);
    run_op("mulhu", 3'b011, 32'hFFFFFFFE, 32'd3, 32'h00000002, CLAT, 1);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFE, 32'hFFFFFFFF,
           32'hFFFFFFFE, CLAT, 1);
    run_op("mul_neg", 3'b000, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, CLAT, 1);
    run_op("div", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, CLAT, 1);
`ifdef MULDIV_RESULT_CACHE_EN
    run_op("rem_hit", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 2, 0);
`else
    run_op("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, CLAT, 1);
`endif
    run_op("divu", 3'b101, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, CLAT, 1);
    run_op("remu", 3'b111, 32'hFFFFFFF9, 32'd2, 32'h00000001, CLAT, 1);
    run_op("divu_z", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 2, 0);
    run_op("rem_z", 3'b110, 32'd5, 32'd0, 32'd5, 2, 0);
    run_op("rem_zneg", 3'b110, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 2, 0);
    run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF,
           32'h80000000, 2, 0);
    run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 2, 0);

    // Flush while the core is busy
    r0 = n_resp;
    req_valid  = 1'b1;
    req_funct3 = 3'b000;
    req_a      = 32'd5;
    req_b      = 32'd5;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    flush     = 1'b1;
    req_valid = 1'b0;
    @(posedge Clk); #1;
    flush = 1'b0;
    bad = 0;
    n = 0;
    while (n < 50) begin
      if (req_ready) bad++;
      if (core_ready) break;
      @(posedge Clk); #1;
      n++;
    end
    chk("drain_ready_low", W'(bad), 32'd0);
    chk("drain_timeout", W'(n < 50), 32'd1);
    @(posedge Clk); #1;
    chk("drain_done_ready", W'(req_ready), 32'd1);
    chk("flush_no_resp", W'(n_resp - r0), 32'd0);
    run_op("mul_after", 3'b000, 32'd3, 32'd3, 32'd9, CLAT, 1);

    repeat (4) @(posedge Clk);
    #1;
    chk("queue_empty", W'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
